// File: rtl/mem_cmd_initiator.sv
// mem_cmd_initiator: host-side initiator for the UART memory-controller command
// protocol. Serialises one read/write request into a byte frame on the uart_tx
// byte port, then collects the response bytes from the uart_rx byte port.
// Optional build macro CMD_CHECKSUM_EN: append an XOR checksum byte to every
// frame and expect a trailing XOR checksum byte on every response.
module mem_cmd_initiator #(
   parameter int unsigned SEL_BITS       = 4,
   parameter int unsigned TIMEOUT_CYCLES = 200000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [SEL_BITS-1:0] req_sel,
   input  logic [7:0]          req_addr,
   input  logic [15:0]         req_wdata,
   output logic [7:0]          tx_data,
   output logic                tx_en,
   input  logic                tx_busy,
   input  logic [7:0]          rx_data,
   input  logic                rx_valid,
   output logic                rsp_valid,
   output logic [15:0]         rsp_rdata,
   output logic                rsp_err
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef CMD_CHECKSUM_EN
   localparam int unsigned CK_BYTES = 1;
`else
   localparam int unsigned CK_BYTES = 0;
`endif
   localparam logic [2:0] TX_LAST_WR = 3'(4 + CK_BYTES);
   localparam logic [2:0] TX_LAST_RD = 3'(2 + CK_BYTES);
   localparam logic [1:0] RX_LAST_WR = 2'(0 + CK_BYTES);
   localparam logic [1:0] RX_LAST_RD = 2'(1 + CK_BYTES);
   localparam logic [7:0] CMD_WR     = 8'h57;
   localparam logic [7:0] CMD_RD     = 8'h52;
   localparam logic [7:0] ACK        = 8'h06;

   typedef enum logic [2:0] {
      IDLE, LOAD, STROBE, WAIT_RISE, WAIT_FALL, RECV, DONE
   } state_t;

   state_t        state_q, state_d;
   logic          wr_q, wr_d;
   logic [7:0]    sel_q, sel_d;
   logic [7:0]    addr_q, addr_d;
   logic [15:0]   wdata_q, wdata_d;
   logic [2:0]    idx_q, idx_d;
   logic [1:0]    rx_idx_q, rx_idx_d;
   logic [7:0]    rx_hi_q, rx_hi_d;
   logic [7:0]    rx_lo_q, rx_lo_d;
   logic [TW-1:0] timer_q, timer_d;

   logic          req_ready_d, tx_en_d, rsp_valid_d, rsp_err_d;
   logic [7:0]    tx_data_d;
   logic [15:0]   rsp_rdata_d;

   logic [7:0]    cmd_byte, frame_csum, frame_byte;
   logic [2:0]    tx_last;
   logic [1:0]    rx_last;

   // Frame byte selection from the captured request fields
   always_comb begin
      cmd_byte   = wr_q ? CMD_WR : CMD_RD;
      frame_csum = cmd_byte ^ sel_q ^ addr_q ^
                   (wr_q ? (wdata_q[15:8] ^ wdata_q[7:0]) : 8'h00);
      tx_last    = wr_q ? TX_LAST_WR : TX_LAST_RD;
      rx_last    = wr_q ? RX_LAST_WR : RX_LAST_RD;
      case (idx_q)
         3'd0:    frame_byte = cmd_byte;
         3'd1:    frame_byte = sel_q;
         3'd2:    frame_byte = addr_q;
         3'd3:    frame_byte = wr_q ? wdata_q[15:8] : frame_csum;
         3'd4:    frame_byte = wdata_q[7:0];
         default: frame_byte = frame_csum;
      endcase
   end

   // State register and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         wr_q      <= 1'b0;
         sel_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         idx_q     <= '0;
         rx_idx_q  <= '0;
         rx_hi_q   <= '0;
         rx_lo_q   <= '0;
         timer_q   <= '0;
         req_ready <= 1'b1;
         tx_data   <= '0;
         tx_en     <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_q      <= wr_d;
         sel_q     <= sel_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         idx_q     <= idx_d;
         rx_idx_q  <= rx_idx_d;
         rx_hi_q   <= rx_hi_d;
         rx_lo_q   <= rx_lo_d;
         timer_q   <= timer_d;
         req_ready <= req_ready_d;
         tx_data   <= tx_data_d;
         tx_en     <= tx_en_d;
         rsp_valid <= rsp_valid_d;
         rsp_rdata <= rsp_rdata_d;
         rsp_err   <= rsp_err_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d     = state_q;
      wr_d        = wr_q;
      sel_d       = sel_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      idx_d       = idx_q;
      rx_idx_d    = rx_idx_q;
      rx_hi_d     = rx_hi_q;
      rx_lo_d     = rx_lo_q;
      timer_d     = timer_q;
      tx_data_d   = tx_data;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata;
      rsp_err_d   = rsp_err;

      case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               wr_d        = req_write;
               sel_d       = 8'(req_sel);
               addr_d      = req_addr;
               wdata_d     = req_wdata;
               idx_d       = '0;
               rx_idx_d    = '0;
               rx_hi_d     = '0;
               rx_lo_d     = '0;
               timer_d     = '0;
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b0;
               state_d     = LOAD;
            end
         end
         LOAD: begin
            tx_data_d = frame_byte;
            if (!tx_busy) state_d = STROBE;
         end
         STROBE: begin
            timer_d = '0;
            state_d = WAIT_RISE;
         end
         // A uart that never raises busy within two cycles is treated as done
         WAIT_RISE: begin
            if (tx_busy || timer_q == TW'(1)) begin
               timer_d = '0;
               state_d = WAIT_FALL;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         WAIT_FALL: begin
            if (!tx_busy) begin
               if (idx_q == tx_last) begin
                  timer_d  = '0;
                  rx_idx_d = '0;
                  state_d  = RECV;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  state_d = LOAD;
               end
            end
         end
         RECV: begin
            if (rx_valid) begin
               timer_d = '0;
               case (rx_idx_q)
                  2'd0:    rx_hi_d = rx_data;
                  2'd1:    rx_lo_d = rx_data;
                  default: ;
               endcase
               if (rx_idx_q == rx_last) begin
                  state_d     = DONE;
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = wr_q ? 16'h0000 : {rx_hi_d, rx_lo_d};
                  rsp_err_d   = wr_q && (rx_hi_d != ACK);
`ifdef CMD_CHECKSUM_EN
                  if (rx_data != (wr_q ? rx_hi_q : (rx_hi_q ^ rx_lo_q)))
                     rsp_err_d = 1'b1;
`endif
               end else begin
                  rx_idx_d = rx_idx_q + 2'd1;
               end
            end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
               state_d     = DONE;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = wr_q ? 16'h0000 : {rx_hi_q, rx_lo_q};
               rsp_err_d   = 1'b1;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      tx_en_d     = (state_d == STROBE);
      req_ready_d = (state_d == IDLE);
   end

endmodule

// File: tb/tb_mem_cmd_initiator.sv
// tb_mem_cmd_initiator: table-driven directed bench for mem_cmd_initiator with a
// simple uart_tx busy model and hand-written reset / stray-byte sequences.
module tb_mem_cmd_initiator;

   localparam int unsigned SEL_BITS = 4;
   localparam int unsigned TMO      = 50;

   logic                clk, reset;
   logic                req_valid, req_ready, req_write;
   logic [SEL_BITS-1:0] req_sel;
   logic [7:0]          req_addr;
   logic [15:0]         req_wdata;
   logic [7:0]          tx_data;
   logic                tx_en, tx_busy;
   logic [7:0]          rx_data;
   logic                rx_valid;
   logic                rsp_valid, rsp_err;
   logic [15:0]         rsp_rdata;

   mem_cmd_initiator #(.SEL_BITS(SEL_BITS), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_sel(req_sel), .req_addr(req_addr), .req_wdata(req_wdata),
      .tx_data(tx_data), .tx_en(tx_en), .tx_busy(tx_busy),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   // Frame bytes: byte i of tx at tx[47-8*i -: 8], byte i of rx at rx[23-8*i -: 8]
   typedef struct {
      logic        wr;
      logic [3:0]  sel;
      logic [7:0]  addr;
      logic [15:0] wdata;
      int          busy;
      bit          stray;
      bit          raw;
      logic [47:0] tx;
      int          n_tx;
      logic [23:0] rx;
      int          n_rx;
      logic        err;
      logic [15:0] rdata;
   } vec_t;

   vec_t       vecs [6];
   vec_t       tv;
   int         n_tests, n_fail;
   int         cyc, fall_cyc, busy_cycles;
   bit         uart_active, lat_armed;
   logic [7:0] txq [$];
   int         ten_cnt, rsp_cnt, rsp_cyc, first_ten_cyc, acc_cyc;
   logic       got_err, ready_at_rsp;
   logic [15:0] got_rdata;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // uart_tx model: logs each strobed byte, then holds busy for busy_cycles
   initial begin
      tx_busy = 1'b0; uart_active = 1'b0; fall_cyc = 0;
      forever begin
         @(negedge clk);
         if (tx_en) begin
            uart_active = 1'b1;
            txq.push_back(tx_data);
            if (busy_cycles > 0) begin
               @(posedge clk); #1; tx_busy = 1'b1;
               repeat (busy_cycles) @(posedge clk);
               #1; tx_busy = 1'b0;
               // posedge at which the DUT first samples busy low
               fall_cyc = cyc + 1;
            end
            uart_active = 1'b0;
         end
      end
   end

   // Output monitor
   initial begin
      ten_cnt = 0; rsp_cnt = 0; rsp_cyc = 0; first_ten_cyc = -1;
      got_err = 1'b0; got_rdata = '0; ready_at_rsp = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_en) begin
            ten_cnt++;
            if (lat_armed) begin
               first_ten_cyc = cyc;
               lat_armed = 1'b0;
            end
         end
         if (rsp_valid) begin
            rsp_cnt++;
            rsp_cyc      = cyc;
            got_err      = rsp_err;
            got_rdata    = rsp_rdata;
            ready_at_rsp = req_ready;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got still running, want finished");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t vin, input string nm);
      vec_t v;
      int   n, rsp0;
`ifdef CMD_CHECKSUM_EN
      logic [7:0] ck;
`endif
      v = vin;
`ifdef CMD_CHECKSUM_EN
      if (!v.raw) begin
         ck = 8'h00;
         for (int i = 0; i < v.n_tx; i++) ck ^= v.tx[47-8*i -: 8];
         v.tx[47-8*v.n_tx -: 8] = ck;
         v.n_tx++;
         if (v.n_rx > 0) begin
            ck = 8'h00;
            for (int i = 0; i < v.n_rx; i++) ck ^= v.rx[23-8*i -: 8];
            v.rx[23-8*v.n_rx -: 8] = ck;
            v.n_rx++;
         end
      end
`endif
      busy_cycles = v.busy;
      txq.delete();
      ten_cnt = 0;
      rsp0    = rsp_cnt;

      @(negedge clk);
      req_valid = 1'b1; req_write = v.wr; req_sel = v.sel;
      req_addr  = v.addr; req_wdata = v.wdata;
      n = 0;
      while (!req_ready && n < 100) begin @(negedge clk); n++; end
      check({nm, "/ready"}, 32'(req_ready), 32'd1);
      acc_cyc = cyc; first_ten_cyc = -1; lat_armed = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      check({nm, "/ready_drop"}, 32'(req_ready), 32'd0);

      if (v.stray) begin
         n = 0;
         while (txq.size() < 2 && n < 500) begin @(negedge clk); n++; end
         rx_data = 8'h06; rx_valid = 1'b1;
         @(negedge clk);
         rx_valid = 1'b0;
      end

      n = 0;
      while (!(txq.size() >= v.n_tx && !uart_active && !tx_busy) && n < 2000) begin
         @(negedge clk); n++;
      end
      check({nm, "/tx_done"}, 32'(n < 2000), 32'd1);
      repeat (6) @(negedge clk);

      for (int i = 0; i < v.n_rx; i++) begin
         rx_data = v.rx[23-8*i -: 8]; rx_valid = 1'b1;
         @(negedge clk);
         rx_valid = 1'b0;
         repeat (2) @(negedge clk);
      end

      n = 0;
      while (rsp_cnt == rsp0 && n < 300) begin @(negedge clk); n++; end
      repeat (3) @(negedge clk);

      check({nm, "/tx_en_count"}, 32'(ten_cnt), 32'(v.n_tx));
      for (int i = 0; i < v.n_tx; i++)
         check($sformatf("%s/tx_byte%0d", nm, i),
               (i < txq.size()) ? 32'(txq[i]) : 32'hFFFF_FFFF, 32'(v.tx[47-8*i -: 8]));
      check({nm, "/latency"}, 32'(first_ten_cyc - acc_cyc), 32'd2);
      check({nm, "/rsp_count"}, 32'(rsp_cnt - rsp0), 32'd1);
      check({nm, "/rsp_err"}, 32'(got_err), 32'(v.err));
      check({nm, "/rsp_rdata"}, 32'(got_rdata), 32'(v.rdata));
      check({nm, "/ready_in_done"}, 32'(ready_at_rsp), 32'd0);
      check({nm, "/ready_after"}, 32'(req_ready), 32'd1);
      check({nm, "/err_held"}, 32'(rsp_err), 32'(v.err));
      if (v.n_rx == 0)
         check({nm, "/timeout_cycles"}, 32'(rsp_cyc - fall_cyc), 32'(TMO));
   endtask

   initial begin
      int n, rsp0, ten0;
      n_tests = 0; n_fail = 0; busy_cycles = 0; lat_armed = 1'b0;
      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_sel = '0;
      req_addr = '0; req_wdata = '0; rx_valid = 1'b0; rx_data = '0;

      //          wr    sel   addr   wdata     busy stray raw tx                     ntx rx           nrx err   rdata
      vecs[0] = '{1'b1, 4'h3, 8'h42, 16'hBEEF, 10, 1'b0, 1'b0, 48'h5703_42BE_EF00, 5, 24'h06_0000, 1, 1'b0, 16'h0000};
      vecs[1] = '{1'b0, 4'h1, 8'h10, 16'h0000, 10, 1'b0, 1'b0, 48'h5201_1000_0000, 3, 24'h12_3400, 2, 1'b0, 16'h1234};
      vecs[2] = '{1'b1, 4'hF, 8'hFF, 16'h0001, 0,  1'b1, 1'b0, 48'h570F_FF00_0100, 5, 24'h15_0000, 1, 1'b1, 16'h0000};
      vecs[3] = '{1'b0, 4'h0, 8'h00, 16'h0000, 3,  1'b0, 1'b0, 48'h5200_0000_0000, 3, 24'hAB_CD00, 2, 1'b0, 16'hABCD};
      vecs[4] = '{1'b0, 4'h8, 8'h80, 16'h0000, 0,  1'b0, 1'b0, 48'h5208_8000_0000, 3, 24'hFF_0000, 2, 1'b0, 16'hFF00};
      vecs[5] = '{1'b0, 4'h2, 8'h20, 16'h0000, 10, 1'b0, 1'b0, 48'h5202_2000_0000, 3, 24'h00_0000, 0, 1'b1, 16'h0000};

      repeat (3) @(negedge clk);
      check("reset/req_ready", 32'(req_ready), 32'd1);
      check("reset/tx_en", 32'(tx_en), 32'd0);
      check("reset/tx_data", 32'(tx_data), 32'd0);
      check("reset/rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset/rsp_rdata", 32'(rsp_rdata), 32'd0);
      check("reset/rsp_err", 32'(rsp_err), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Stray rx byte while idle is dropped
      rsp0 = rsp_cnt;
      rx_data = 8'h06; rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("idle_stray/no_rsp", 32'(rsp_cnt - rsp0), 32'd0);
      check("idle_stray/ready", 32'(req_ready), 32'd1);

      for (int k = 0; k < 6; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

      // Reset right after the byte1 strobe aborts the frame silently
      busy_cycles = 10;
      txq.delete();
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_sel = 4'h5; req_addr = 8'h33;
      check("rst_mid/ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (txq.size() < 2 && n < 500) begin @(negedge clk); n++; end
      check("rst_mid/byte1_seen", 32'(txq.size()), 32'd2);
      reset = 1'b1;
      @(negedge clk);
      check("rst_mid/ready_next", 32'(req_ready), 32'd1);
      check("rst_mid/tx_en", 32'(tx_en), 32'd0);
      check("rst_mid/rsp_valid", 32'(rsp_valid), 32'd0);
      reset = 1'b0;
      ten0 = ten_cnt; rsp0 = rsp_cnt;
      repeat (40) @(negedge clk);
      check("rst_mid/no_tx_en", 32'(ten_cnt - ten0), 32'd0);
      check("rst_mid/no_rsp", 32'(rsp_cnt - rsp0), 32'd0);

      tv = '{1'b0, 4'h7, 8'h99, 16'h0000, 2, 1'b0, 1'b0, 48'h5207_9900_0000, 3, 24'h5A_A500, 2, 1'b0, 16'h5AA5};
      run_vec(tv, "recover");

`ifdef CMD_CHECKSUM_EN
      tv = '{1'b0, 4'h2, 8'h05, 16'h0000, 10, 1'b0, 1'b1, 48'h5202_0555_0000, 4, 24'h12_3426, 3, 1'b0, 16'h1234};
      run_vec(tv, "ck_good");
      tv = '{1'b0, 4'h2, 8'h05, 16'h0000, 10, 1'b0, 1'b1, 48'h5202_0555_0000, 4, 24'h12_3400, 3, 1'b1, 16'h1234};
      run_vec(tv, "ck_bad");
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
